// File: rtl/deserializer_pkg.sv
// Shared constants and helpers for the deserializer block.
// Supplies the counter-width function used by the top level.
package deserializer_pkg;

   // Ceiling log2, never less than 1 so a counter always has at least one bit.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      int unsigned span;
      result = 0;
      span   = 1;
      while (span < value) begin
         span   = span * 2;
         result = result + 1;
      end
      if (result == 0) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/deserializer_if.sv
// Symbol-in / word-out bus of the deserializer.
// master: symbol producer and word consumer; slave: the deserializer itself.
interface deserializer_if #(
   parameter int unsigned depth = 4,
   parameter int unsigned width = 8
);
   logic [width-1:0]       serial_in;
   logic                   serial_valid;
   logic                   serial_sync;
   logic                   serial_ready;
   logic [depth*width-1:0] parallel_out;
   logic                   out_valid;
   logic                   out_ready;
   logic                   partial_drop;

   modport master (
      output serial_in, serial_valid, serial_sync, out_ready,
      input  serial_ready, parallel_out, out_valid, partial_drop
   );

   modport slave (
      input  serial_in, serial_valid, serial_sync, out_ready,
      output serial_ready, parallel_out, out_valid, partial_drop
   );
endinterface

// File: rtl/deserializer_shifter.sv
// Shift register of `stages` symbols; new symbols enter the top slice and
// older ones move toward the LSB slice. Storage is intentionally unreset.
module deserializer_shifter #(
   parameter int unsigned stages = 3,
   parameter int unsigned width  = 8
) (
   input  logic                      clock,
   input  logic                      enable,
   input  logic                      load,
   input  logic [stages*width-1:0]   parallel_in,
   input  logic [width-1:0]          serial_in,
   output logic [stages*width-1:0]   parallel_out
);
   logic [stages*width-1:0] data_q;
   logic [stages*width-1:0] shifted;

   if (stages > 1) begin : gen_multi
      assign shifted = {serial_in, data_q[stages*width-1:width]};
   end else begin : gen_single
      assign shifted = serial_in;
   end

   // Parallel load wins over a shift.
   always_ff @(posedge clock) begin
      if (load) begin
         data_q <= parallel_in;
      end else if (enable) begin
         data_q <= shifted;
      end
   end

   assign parallel_out = data_q;
endmodule

// File: rtl/deserializer.sv
// Deserializer: collects `depth` symbols of `width` bits into one word,
// first symbol in the LSB slice, with valid/ready handshakes on both sides.
// Optional sticky partial-word flag: define DESERIALIZER_PARTIAL_DROP_EN.
module deserializer
   import deserializer_pkg::*;
#(
   parameter int unsigned depth = 4,
   parameter int unsigned width = 8
) (
   input logic           clock,
   input logic           reset,
   deserializer_if.slave bus
);
   localparam int unsigned     cnt_w      = clog2(depth);
   localparam logic [cnt_w-1:0] last_count = cnt_w'(depth - 1);

   if (depth < 2) begin : gen_bad_depth
      $error("deserializer: depth must be at least 2");
   end
   if (width < 1) begin : gen_bad_width
      $error("deserializer: width must be at least 1");
   end

   logic [cnt_w-1:0]             count_q, count_d;
   logic                         valid_q, valid_d;
   logic [depth*width-1:0]       word_q, word_d;
   logic [(depth-1)*width-1:0]   stored;
   logic                         ready;
   logic                         transfer;
   logic                         accept;
   logic                         at_last;
   logic                         complete;

   assign at_last = (count_q == last_count);
   // Stall only the final symbol, and only while the held word is not leaving.
   assign ready    = !(at_last && valid_q && !bus.out_ready);
   assign transfer = bus.serial_valid && ready;
   assign accept   = valid_q && bus.out_ready;
   // A sync symbol restarts the word, so it never completes one.
   assign complete = transfer && !bus.serial_sync && at_last;

   // Symbols 0..depth-2 live in the shifter; the last one is taken straight
   // from serial_in. The counter only reaches depth-1 after depth-1 fresh
   // shifts, so unreset shifter contents can never appear in a word.
   deserializer_shifter #(
      .stages (depth - 1),
      .width  (width)
   ) u_shifter (
      .clock        (clock),
      .enable       (transfer),
      .load         (1'b0),
      .parallel_in  ('0),
      .serial_in    (bus.serial_in),
      .parallel_out (stored)
   );

   // Next-state for the symbol counter and the output word register.
   always_comb begin
      count_d = count_q;
      valid_d = valid_q;
      word_d  = word_q;
      if (transfer) begin
         if (bus.serial_sync) begin
            count_d = cnt_w'(1);
         end else if (at_last) begin
            count_d = '0;
         end else begin
            count_d = count_q + cnt_w'(1);
         end
      end
      if (complete) begin
         valid_d = 1'b1;
         word_d  = {bus.serial_in, stored};
      end else if (accept) begin
         valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
         valid_q <= 1'b0;
         word_q  <= '0;
      end else begin
         count_q <= count_d;
         valid_q <= valid_d;
         word_q  <= word_d;
      end
   end

`ifdef DESERIALIZER_PARTIAL_DROP_EN
   logic drop_q, drop_d;

   // Sticky: set when a sync symbol arrives mid-word.
   always_comb begin
      drop_d = drop_q;
      if (transfer && bus.serial_sync && (count_q != '0)) begin
         drop_d = 1'b1;
      end
   end

   // Flag register, cleared only by reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         drop_q <= 1'b0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign bus.partial_drop = drop_q;
`else
   assign bus.partial_drop = 1'b0;
`endif

   assign bus.serial_ready = ready;
   assign bus.parallel_out = word_q;
   assign bus.out_valid    = valid_q;
endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer (depth=4, width=8) with a word scoreboard.
module tb_deserializer;
   localparam int unsigned depth = 4;
   localparam int unsigned width = 8;
`ifdef DESERIALIZER_PARTIAL_DROP_EN
   localparam logic drop_en = 1'b1;
`else
   localparam logic drop_en = 1'b0;
`endif

   logic clock;
   logic reset;
   int   tests;
   int   fails;

   logic [31:0] exp_q [$];
   int          m_cnt;
   logic [31:0] m_word;
   logic        hold_prev;
   logic [31:0] po_prev;

   deserializer_if #(.depth(depth), .width(width)) bus ();

   deserializer #(
      .depth (depth),
      .width (width)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one symbol from posedge+1; returns at posedge+1 after its transfer.
   task automatic send(input logic [7:0] d, input logic s);
      int n;
      bus.serial_valid = 1'b1;
      bus.serial_in    = d;
      bus.serial_sync  = s;
      n = 0;
      @(negedge clock);
      while (bus.serial_ready !== 1'b1 && n < 50) begin
         n++;
         @(negedge clock);
      end
      chk("send_ready", {63'd0, bus.serial_ready}, 64'd1);
      if (s) begin
         m_word       = 32'd0;
         m_word[7:0]  = d;
         m_cnt        = 1;
      end else begin
         m_word[m_cnt*8 +: 8] = d;
         if (m_cnt == 3) begin
            exp_q.push_back(m_word);
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end
      @(posedge clock);
      #1;
      bus.serial_valid = 1'b0;
      bus.serial_sync  = 1'b0;
   endtask

   // Idle cycles with junk on serial_in/serial_sync that must be ignored.
   task automatic idle(input int n);
      bus.serial_valid = 1'b0;
      bus.serial_sync  = 1'b1;
      repeat (n) begin
         bus.serial_in = 8'($urandom);
         @(posedge clock);
         #1;
      end
      bus.serial_sync = 1'b0;
   endtask

   // Scoreboard pop on every word accept, plus hold-stability of parallel_out.
   always @(negedge clock) begin
      if (hold_prev) begin
         tests++;
         assert (bus.parallel_out === po_prev) else begin
            fails++;
            $error("FAIL hold_stable observed=%0h expected=%0h", bus.parallel_out, po_prev);
         end
      end
      hold_prev = !reset && bus.out_valid && !bus.out_ready;
      po_prev   = bus.parallel_out;
      if (!reset && bus.out_valid && bus.out_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL sb_unexpected observed=%0h expected=none", bus.parallel_out);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            assert (bus.parallel_out === e) else begin
               fails++;
               $error("FAIL sb_word observed=%0h expected=%0h", bus.parallel_out, e);
            end
         end
      end
   end

   initial begin
      #100000;
      fails++;
      $display("FAIL watchdog observed=timeout expected=finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      tests = 0;
      fails = 0;
      m_cnt = 0;
      m_word = 32'd0;
      hold_prev = 1'b0;
      po_prev = 32'd0;
      reset = 1'b1;
      bus.serial_in = 8'd0;
      bus.serial_valid = 1'b0;
      bus.serial_sync = 1'b0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_word", {32'd0, bus.parallel_out}, 64'd0);
      chk("rst_drop", {63'd0, bus.partial_drop}, 64'd0);
      chk("rst_ready", {63'd0, bus.serial_ready}, 64'd1);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Basic word, accepted as soon as it appears
      bus.out_ready = 1'b1;
      send(8'h11, 1'b1);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b0);
      @(negedge clock);
      chk("w1_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("w1_word", {32'd0, bus.parallel_out}, 64'h44332211);
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("w1_cleared", {63'd0, bus.out_valid}, 64'd0);
      @(posedge clock);
      #1;

      // Back-to-back words with stalled consumer; release while 4th is pending
      bus.out_ready = 1'b0;
      send(8'hA1, 1'b1);
      send(8'hA2, 1'b0);
      send(8'hA3, 1'b0);
      send(8'hA4, 1'b0);
      send(8'hB1, 1'b0);
      send(8'hB2, 1'b0);
      send(8'hB3, 1'b0);
      fork
         send(8'hB4, 1'b0);
         begin
            repeat (3) begin
               @(negedge clock);
               chk("stall_ready", {63'd0, bus.serial_ready}, 64'd0);
               chk("stall_word", {32'd0, bus.parallel_out}, 64'hA4A3A2A1);
            end
            @(posedge clock);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      @(negedge clock);
      chk("nobubble_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("nobubble_word", {32'd0, bus.parallel_out}, 64'hB4B3B2B1);
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("w2_cleared", {63'd0, bus.out_valid}, 64'd0);
      @(posedge clock);
      #1;

      // Partial word dropped by a sync
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      send(8'h01, 1'b1);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      send(8'h04, 1'b0);
      @(negedge clock);
      chk("drop_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("drop_word", {32'd0, bus.parallel_out}, 64'h04030201);
      chk("drop_flag", {63'd0, bus.partial_drop}, {63'd0, drop_en});
      @(posedge clock);
      #1;

      // Reset mid-word
      bus.out_ready = 1'b0;
      send(8'h55, 1'b1);
      send(8'h66, 1'b0);
      reset = 1'b1;
      m_cnt = 0;
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("rst1_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst1_word", {32'd0, bus.parallel_out}, 64'd0);
      chk("rst1_drop", {63'd0, bus.partial_drop}, 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      send(8'h77, 1'b0);
      send(8'h78, 1'b0);
      send(8'h79, 1'b0);
      send(8'h7A, 1'b0);
      @(negedge clock);
      chk("postrst_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("postrst_word", {32'd0, bus.parallel_out}, 64'h7A797877);
      @(posedge clock);
      #1;

      // Reset while a word is waiting
      reset = 1'b1;
      exp_q.delete();
      m_cnt = 0;
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("rst2_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst2_word", {32'd0, bus.parallel_out}, 64'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      bus.out_ready = 1'b1;
      send(8'hC1, 1'b0);
      send(8'hC2, 1'b0);
      send(8'hC3, 1'b0);
      send(8'hC4, 1'b0);
      @(negedge clock);
      chk("clean_word", {32'd0, bus.parallel_out}, 64'hC4C3C2C1);
      @(posedge clock);
      #1;

      // Gaps, including gaps while serial_ready is low
      send(8'hD0, 1'b1);
      idle(2);
      send(8'hD1, 1'b0);
      idle(1);
      send(8'hD2, 1'b0);
      send(8'hD3, 1'b0);
      idle(3);
      bus.out_ready = 1'b0;
      send(8'hE0, 1'b1);
      idle(1);
      send(8'hE1, 1'b0);
      send(8'hE2, 1'b0);
      send(8'hE3, 1'b0);
      send(8'hF0, 1'b0);
      idle(2);
      send(8'hF1, 1'b0);
      send(8'hF2, 1'b0);
      bus.serial_valid = 1'b0;
      repeat (3) begin
         @(negedge clock);
         chk("gap_ready", {63'd0, bus.serial_ready}, 64'd0);
         chk("gap_word", {32'd0, bus.parallel_out}, 64'hE3E2E1E0);
         @(posedge clock);
         #1;
      end
      bus.out_ready = 1'b1;
      send(8'hF3, 1'b0);
      @(negedge clock);
      chk("gap_last_word", {32'd0, bus.parallel_out}, 64'hF3F2F1F0);
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("final_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("final_drop", {63'd0, bus.partial_drop}, 64'd0);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter depth, default 4: symbols per word; legal range 2 or more.
REQ-002 SHALL have parameter width, default 8: bits per symbol; legal range 1 or more.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port serial_in, input, width: incoming symbol.
REQ-006 SHALL have port serial_valid, input, 1: serial_in is valid.
REQ-007 SHALL have port serial_sync, input, 1: the symbol in this cycle starts a new word.
REQ-008 SHALL have port serial_ready, output, 1: block accepts a symbol this cycle.
REQ-009 SHALL have port parallel_out, output, depth*width: assembled word.
REQ-010 SHALL have port out_valid, output, 1: parallel_out holds an unconsumed word.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the word.
REQ-012 SHALL have port partial_drop, output, 1: sticky flag for a discarded partial word.

Function
REQ-013 SHALL define a symbol transfer as serial_valid and serial_ready both high in the same cycle; a word accept is out_valid and out_ready both high.
REQ-014 SHALL keep a symbol counter, 0 to depth-1, that advances by 1 on each transfer.
REQ-015 SHALL place the k-th symbol of a word (k=0 first) at parallel_out[(k+1)*width-1 -: width], so the first symbol lands in the LSB slice.
REQ-016 SHALL, when a transfer occurs with counter equal to depth-1, load parallel_out with the new word, set out_valid, and return the counter to 0; latency is one cycle from the last symbol to out_valid.
REQ-017 SHALL drive serial_ready low only when the counter equals depth-1, out_valid is high and out_ready is low; otherwise it is high (combinational from out_ready).
REQ-018 SHALL clear out_valid on a word accept, unless a word completes in the same cycle; in that case out_valid stays 1 and parallel_out takes the new word.
REQ-019 SHALL hold parallel_out stable while out_valid is high and no accept occurs.
REQ-020 SHALL treat a transfer with serial_sync high as symbol 0: the counter becomes 1 and any partial word is discarded.
REQ-021 SHALL ignore serial_sync and serial_in when no transfer occurs.

Reset
REQ-022 SHALL, on reset, set the counter to 0, out_valid to 0, parallel_out to 0 and partial_drop to 0; reset has priority over every other event.
REQ-023 SHALL discard any partial word and any unaccepted word on a reset asserted mid-word.
REQ-024 SHALL NOT require the symbol storage to be reset; stale contents SHALL never reach parallel_out in place of received symbols.

Configuration
REQ-025 SHALL, with macro DESERIALIZER_PARTIAL_DROP_EN defined, set partial_drop to 1 on a transfer with serial_sync high while the counter is not 0; it stays set until reset.
REQ-026 SHALL, without DESERIALIZER_PARTIAL_DROP_EN, tie partial_drop to 0 and contain no logic for it; all other behaviour is identical.

Structure
REQ-027 SHALL take its counter-width constant/function (ceiling log2 of depth) from the team's shared package; no local copy.
REQ-028 SHALL store symbols 0 to depth-2 in one existing shifter instance with depth-1 stages, width bits, enable = transfer, load = 0 and serial_in = serial_in.
REQ-029 SHALL form the completed word as {serial_in, shifter parallel_out}.

Verification (depth=4, width=8)
REQ-030 SHALL test: sync with 0x11, then 0x22, 0x33, 0x44, out_ready=1 -> out_valid=1 one cycle after 0x44, parallel_out=0x44332211, accepted the same cycle.
REQ-031 SHALL test: two words back-to-back, out_ready=0 -> second word stalls with serial_ready=0 at its 4th symbol; raising out_ready -> first word accepted, second word appears the next cycle, no symbol lost.
REQ-032 SHALL test: accept and completion in the same cycle -> out_valid stays 1 and parallel_out changes to the new word with no bubble.
REQ-033 SHALL test: 0xAA, 0xBB, then sync with 0x01, 0x02, 0x03, 0x04 -> word 0x04030201; partial_drop=1 with the macro, 0 without.
REQ-034 SHALL test: reset after 2 symbols and again with out_valid=1 -> all outputs 0 the next cycle; the next 4 symbols form a clean word.
REQ-035 SHALL test: serial_valid toggling with gaps, including gaps while serial_ready=0 -> word order is unchanged and the counter does not advance on idle cycles.
